regfile_dump: RTL and testbench

Debug-side reader for the 32×32 register file. On a start pulse, it walks an inclusive address window through a dedicated register-file read port and streams each register value out over a valid/ready interface. It also accumulates a 32-bit sum of the words it sends. It sits between the core's register file and the debug/trace unit, and lets the bench or a debug host snapshot architectural state without stopping the core.

---
 rtl/regfile_dump.sv | 87 ++++++++
 tb/tb_regfile_dump.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks an inclusive register window through a read port and
// streams each word over valid/ready while accumulating a 32-bit checksum.
module regfile_dump (
    input  logic        clk,
    input  logic        in_rst_n,
    input  logic        in_start,
    input  logic [4:0]  in_first_addr,
    input  logic [4:0]  in_last_addr,
    output logic [4:0]  out_rf_read_address,
    input  logic [31:0] in_rf_read_data,
    output logic        out_valid,
    input  logic        in_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_addr,
    output logic        out_last,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_checksum
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_nx;
    logic [4:0]  last_q, last_nx, cur_nx, addr_nx;
    logic [31:0] data_nx, sum_nx;
    logic        valid_nx, beat_last_nx, done_nx, capture;

    assign out_busy = (state != IDLE);

    always_comb begin
        state_nx     = state;
        cur_nx       = out_rf_read_address;
        last_nx      = last_q;
        addr_nx      = out_addr;
        data_nx      = out_data;
        sum_nx       = out_checksum;
        valid_nx     = out_valid;
        beat_last_nx = out_last;
        done_nx      = 1'b0;
        capture      = (state == RUN) && (!out_valid || in_ready);
        // a start coinciding with the done pulse belongs to the finished dump
        if (state == IDLE && in_start && !out_done) begin
            state_nx = RUN;
            cur_nx   = in_first_addr;
            last_nx  = in_last_addr;
            sum_nx   = '0;
        end
        if (capture) begin
            data_nx      = in_rf_read_data;
            addr_nx      = out_rf_read_address;
            valid_nx     = 1'b1;
            sum_nx       = out_checksum + in_rf_read_data;
            beat_last_nx = (out_rf_read_address == last_q);
            cur_nx       = out_rf_read_address + 5'd1;
            state_nx     = (out_rf_read_address == last_q) ? DRAIN : RUN;
        end
        if (state == DRAIN && out_valid && in_ready) begin
            valid_nx     = 1'b0;
            beat_last_nx = 1'b0;
            done_nx      = 1'b1;
            state_nx     = IDLE;
        end
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state               <= IDLE;
            out_rf_read_address <= '0;
            last_q              <= '0;
            out_valid           <= 1'b0;
            out_data            <= '0;
            out_addr            <= '0;
            out_last            <= 1'b0;
            out_done            <= 1'b0;
            out_checksum        <= '0;
        end else begin
            state               <= state_nx;
            out_rf_read_address <= cur_nx;
            last_q              <= last_nx;
            out_valid           <= valid_nx;
            out_data            <= data_nx;
            out_addr            <= addr_nx;
            out_last            <= beat_last_nx;
            out_done            <= done_nx;
            out_checksum        <= sum_nx;
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed scenarios for regfile_dump with a behavioural register file.
module tb_regfile_dump;
    logic        clk = 1'b0;
    logic        in_rst_n, in_start, in_ready, out_valid, out_last, out_busy, out_done;
    logic [4:0]  in_first_addr, in_last_addr, out_rf_read_address, out_addr;
    logic [31:0] in_rf_read_data, out_data, out_checksum;
    logic [31:0] rf [32];

    int errors = 0;
    int checks = 0;

    logic [4:0]  beat_addr [40];
    logic [31:0] beat_data [40];
    logic        beat_last [40];
    int          nbeats, done_ofs;
    logic [31:0] done_sum;
    logic        stable_ok;

    regfile_dump dut (
        .clk(clk), .in_rst_n(in_rst_n), .in_start(in_start),
        .in_first_addr(in_first_addr), .in_last_addr(in_last_addr),
        .out_rf_read_address(out_rf_read_address), .in_rf_read_data(in_rf_read_data),
        .out_valid(out_valid), .in_ready(in_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .out_busy(out_busy),
        .out_done(out_done), .out_checksum(out_checksum)
    );

    always #5 clk = ~clk;
    assign in_rf_read_data = (out_rf_read_address == 5'd0) ? 32'd0 : rf[out_rf_read_address];

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        in_start = 1'b1; in_first_addr = f; in_last_addr = l;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    // Records accepted beats; c counts negedges after the start edge k.
    task automatic collect(input logic [63:0] rdy, input int poke);
        logic pv, pl;
        logic [31:0] pd;
        logic [4:0] pa;
        nbeats = 0; done_ofs = 0; stable_ok = 1'b1; pv = 1'b0; done_sum = '0;
        pd = '0; pa = '0; pl = 1'b0;
        for (int c = 0; c < 200; c++) begin
            in_ready = (c < 64) ? rdy[c] : 1'b1;
            if (c == poke) begin
                in_start = 1'b1; in_first_addr = 5'd0; in_last_addr = 5'd0;
                rf[20] = 32'h12345678; rf[11] = 32'hAAAAAAAA;
            end else in_start = 1'b0;
            if (pv && (out_data !== pd || out_addr !== pa || out_last !== pl)) stable_ok = 1'b0;
            if (out_valid && in_ready && nbeats < 40) begin
                beat_addr[nbeats] = out_addr; beat_data[nbeats] = out_data;
                beat_last[nbeats] = out_last; nbeats++;
            end
            pv = out_valid && !in_ready; pd = out_data; pa = out_addr; pl = out_last;
            @(negedge clk);
            if (out_done) begin
                done_ofs = c + 1; done_sum = out_checksum;
                break;
            end
        end
        in_start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({out_valid, out_data, out_addr, out_last, out_busy, out_done, out_checksum, out_rf_read_address} !== '0) begin
            errors++; $display("FAIL reset_outputs: got v=%b d=%h a=%0d l=%b b=%b dn=%b s=%h ra=%0d required all 0",
                out_valid, out_data, out_addr, out_last, out_busy, out_done, out_checksum, out_rf_read_address);
        end
        @(negedge clk); @(negedge clk);
        in_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full;
        logic [31:0] sum = 0;
        for (int k = 0; k < 32; k++) rf[k] = k * 32'h01010101;
        @(negedge clk);
        start_dump(5'd0, 5'd31);
        checks++;
        if (out_busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_start_latency: got busy=%b valid=%b required busy=1 valid=0", out_busy, out_valid);
        end
        collect('1, -1);
        checks++;
        if (nbeats !== 32) begin errors++; $display("FAIL full_beats: got %0d required 32", nbeats); end
        for (int i = 0; i < nbeats && i < 32; i++) begin
            sum += i * 32'h01010101;
            checks++;
            if (beat_addr[i] !== 5'(i) || beat_data[i] !== i * 32'h01010101 || beat_last[i] !== (i == 31)) begin
                errors++; $display("FAIL full_beat%0d: got a=%0d d=%h l=%b required a=%0d d=%h l=%b",
                    i, beat_addr[i], beat_data[i], beat_last[i], i, i * 32'h01010101, i == 31);
            end
        end
        checks++;
        if (done_ofs !== 33) begin errors++; $display("FAIL full_done_edge: got k+%0d required k+33", done_ofs); end
        checks++;
        if (done_sum !== sum || sum !== 32'hF1F1F1F0) begin
            errors++; $display("FAIL full_checksum: got %h required %h", done_sum, 32'hF1F1F1F0);
        end
        checks++;
        if (out_busy !== 1'b0) begin errors++; $display("FAIL full_busy_after_done: got %b required 0", out_busy); end
        @(negedge clk);
        checks++;
        if (out_done !== 1'b0 || out_checksum !== 32'hF1F1F1F0) begin
            errors++; $display("FAIL full_done_pulse: got done=%b sum=%h required done=0 sum=f1f1f1f0", out_done, out_checksum);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] sum = 0;
        logic [4:0] a;
        logic [31:0] d;
        @(negedge clk);
        start_dump(5'd30, 5'd1);
        collect('1, -1);
        checks++;
        if (nbeats !== 4 || done_ofs !== 5) begin
            errors++; $display("FAIL wrap_count: got beats=%0d done=k+%0d required beats=4 done=k+5", nbeats, done_ofs);
        end
        for (int i = 0; i < nbeats && i < 4; i++) begin
            a = 5'(30 + i);
            d = (a == 5'd0) ? 32'd0 : rf[a];
            sum += d;
            checks++;
            if (beat_addr[i] !== a || beat_data[i] !== d || beat_last[i] !== (i == 3)) begin
                errors++; $display("FAIL wrap_beat%0d: got a=%0d d=%h l=%b required a=%0d d=%h l=%b",
                    i, beat_addr[i], beat_data[i], beat_last[i], a, d, i == 3);
            end
        end
        checks++;
        if (done_sum !== sum) begin errors++; $display("FAIL wrap_checksum: got %h required %h", done_sum, sum); end
    endtask

    task automatic test_single;
        rf[5] = 32'hDEADBEEF;
        @(negedge clk);
        start_dump(5'd5, 5'd5);
        collect('1, -1);
        checks++;
        if (nbeats !== 1 || beat_addr[0] !== 5'd5 || beat_data[0] !== 32'hDEADBEEF || beat_last[0] !== 1'b1) begin
            errors++; $display("FAIL single_beat: got n=%0d a=%0d d=%h l=%b required n=1 a=5 d=deadbeef l=1",
                nbeats, beat_addr[0], beat_data[0], beat_last[0]);
        end
        checks++;
        if (done_ofs !== 2 || done_sum !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_done: got k+%0d sum=%h required k+2 sum=deadbeef", done_ofs, done_sum);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] rdy = '1;
        rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[4] = 1'b0; rdy[7] = 1'b0; rdy[8] = 1'b0;
        @(negedge clk);
        start_dump(5'd3, 5'd6);
        collect(rdy, -1);
        checks++;
        if (nbeats !== 4) begin errors++; $display("FAIL bp_beats: got %0d required 4", nbeats); end
        for (int i = 0; i < nbeats && i < 4; i++) begin
            checks++;
            if (beat_addr[i] !== 5'(3 + i) || beat_data[i] !== rf[3 + i] || beat_last[i] !== (i == 3)) begin
                errors++; $display("FAIL bp_beat%0d: got a=%0d d=%h l=%b required a=%0d d=%h l=%b",
                    i, beat_addr[i], beat_data[i], beat_last[i], 3 + i, rf[3 + i], i == 3);
            end
        end
        checks++;
        if (stable_ok !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b required 1", stable_ok); end
        checks++;
        if (done_ofs !== 10) begin errors++; $display("FAIL bp_done_edge: got k+%0d required k+10", done_ofs); end
    endtask

    task automatic test_start_busy_write;
        logic [31:0] r11 = rf[11];
        logic [31:0] d;
        @(negedge clk);
        start_dump(5'd10, 5'd25);
        collect('1, 3);
        checks++;
        if (nbeats !== 16 || done_ofs !== 17) begin
            errors++; $display("FAIL busy_count: got beats=%0d done=k+%0d required beats=16 done=k+17", nbeats, done_ofs);
        end
        for (int i = 0; i < nbeats && i < 16; i++) begin
            d = (i == 10) ? 32'h12345678 : (i == 1) ? r11 : rf[10 + i];
            checks++;
            if (beat_addr[i] !== 5'(10 + i) || beat_data[i] !== d) begin
                errors++; $display("FAIL busy_beat%0d: got a=%0d d=%h required a=%0d d=%h",
                    i, beat_addr[i], beat_data[i], 10 + i, d);
            end
        end
        in_start = 1'b1; in_first_addr = 5'd0; in_last_addr = 5'd0;
        @(negedge clk);
        in_start = 1'b0;
        checks++;
        if (out_busy !== 1'b0) begin errors++; $display("FAIL start_with_done: got busy=%b required 0", out_busy); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        repeat (4) @(negedge clk);
        #2 in_rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_addr, out_last, out_busy, out_done, out_checksum, out_rf_read_address} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got v=%b d=%h a=%0d l=%b b=%b dn=%b s=%h ra=%0d required all 0",
                out_valid, out_data, out_addr, out_last, out_busy, out_done, out_checksum, out_rf_read_address);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (out_done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b required 0", out_done); end
        end
        in_rst_n = 1'b1;
        @(negedge clk);
        start_dump(5'd2, 5'd4);
        collect('1, -1);
        checks++;
        if (nbeats !== 3 || done_ofs !== 4 || beat_addr[0] !== 5'd2 || beat_addr[2] !== 5'd4
            || done_sum !== rf[2] + rf[3] + rf[4]) begin
            errors++; $display("FAIL post_reset_dump: got n=%0d done=k+%0d a0=%0d a2=%0d sum=%h required n=3 done=k+4 a0=2 a2=4 sum=%h",
                nbeats, done_ofs, beat_addr[0], beat_addr[2], done_sum, rf[2] + rf[3] + rf[4]);
        end
    endtask

    initial begin
        in_rst_n = 1'b0; in_start = 1'b0; in_ready = 1'b0;
        in_first_addr = '0; in_last_addr = '0;
        for (int k = 0; k < 32; k++) rf[k] = '0;
        test_reset;
        test_full;
        test_wrap;
        test_single;
        test_backpressure;
        test_start_busy_write;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
